// File: rtl/adder_digit_serial.sv
// Digit-serial adder: adds two p_nbits operands p_ndigit bits per cycle behind val/rdy handshakes.
// Optional subtract mode (in_sub port) is enabled by defining ADDER_DIGIT_SERIAL_SUB_EN.
//
// state | meaning
// IDLE  | ready for operands, in_rdy=1
// CALC  | one digit added per cycle, LSB digit first
// DONE  | result valid, held until out_rdy
module adder_digit_serial #(
    parameter int p_nbits  = 8,
    parameter int p_ndigit = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_a,
    input  logic [p_nbits-1:0] in_b,
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
    input  logic               in_sub,
`endif
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_sum,
    output logic               out_cout
);

    localparam int N  = p_nbits / p_ndigit;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [p_nbits-1:0]   r_a;
    logic [p_nbits-1:0]   r_b;
    logic [p_nbits-1:0]   r_sum;
    logic                 r_carry;
    logic [CW-1:0]        r_cnt;

    logic                 w_fire;
    logic                 w_calc;
    logic                 w_last;
    logic [p_ndigit:0]    w_digit;
    logic [p_nbits-1:0]   w_sum_next;
    logic [p_nbits-1:0]   w_b_load;
    logic                 w_carry_init;

`ifdef ADDER_DIGIT_SERIAL_SUB_EN
    // Two's-complement subtract: A + ~B + 1
    assign w_b_load     = in_sub ? ~in_b : in_b;
    assign w_carry_init = in_sub;
`else
    assign w_b_load     = in_b;
    assign w_carry_init = 1'b0;
`endif

    assign w_last  = (r_cnt == CW'(N - 1));
    assign w_digit = {1'b0, r_a[p_ndigit-1:0]} + {1'b0, r_b[p_ndigit-1:0]}
                   + {{p_ndigit{1'b0}}, r_carry};
    // New digit enters at the top so that after N steps the first digit sits at the LSB
    assign w_sum_next = (r_sum >> p_ndigit)
                      | (p_nbits'(w_digit[p_ndigit-1:0]) << (p_nbits - p_ndigit));

    always_comb begin
        w_state_next = r_state;
        in_rdy       = 1'b0;
        out_val      = 1'b0;
        w_fire       = 1'b0;
        w_calc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_rdy = 1'b1;
                if (in_val) begin
                    w_fire       = 1'b1;
                    w_state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                w_calc = 1'b1;
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                out_val = 1'b1;
                if (out_rdy) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_fire) begin
            r_a     <= in_a;
            r_b     <= w_b_load;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
        end else if (w_calc) begin
            r_a     <= r_a >> p_ndigit;
            r_b     <= r_b >> p_ndigit;
            r_sum   <= w_sum_next;
            r_carry <= w_digit[p_ndigit];
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign out_sum  = r_sum;
    assign out_cout = r_carry;

endmodule

// File: tb/tb_adder_digit_serial.sv
// Bench for adder_digit_serial: four parameter configurations checked against an arithmetic model.
// Subtract-mode checks are compiled in when ADDER_DIGIT_SERIAL_SUB_EN is defined.
module tb_adder_digit_serial;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iv    [4];
    logic        ordy  [4];
    logic        irdy  [4];
    logic        oval  [4];
    logic        ocout [4];
    logic [7:0]  a8    [3];
    logic [7:0]  b8    [3];
    logic [7:0]  s8    [3];
    logic [31:0] a32, b32, s32;
    logic        sub_sel = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int exp_lat [4] = '{4, 1, 8, 8};

    always #5 clk = ~clk;

    adder_digit_serial #(.p_nbits(8), .p_ndigit(2)) dut0 (
        .clk(clk), .reset(reset), .in_val(iv[0]), .in_rdy(irdy[0]),
        .in_a(a8[0]), .in_b(b8[0]),
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
        .in_sub(sub_sel),
`endif
        .out_val(oval[0]), .out_rdy(ordy[0]), .out_sum(s8[0]), .out_cout(ocout[0]));

    adder_digit_serial #(.p_nbits(8), .p_ndigit(8)) dut1 (
        .clk(clk), .reset(reset), .in_val(iv[1]), .in_rdy(irdy[1]),
        .in_a(a8[1]), .in_b(b8[1]),
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
        .in_sub(sub_sel),
`endif
        .out_val(oval[1]), .out_rdy(ordy[1]), .out_sum(s8[1]), .out_cout(ocout[1]));

    adder_digit_serial #(.p_nbits(8), .p_ndigit(1)) dut2 (
        .clk(clk), .reset(reset), .in_val(iv[2]), .in_rdy(irdy[2]),
        .in_a(a8[2]), .in_b(b8[2]),
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
        .in_sub(sub_sel),
`endif
        .out_val(oval[2]), .out_rdy(ordy[2]), .out_sum(s8[2]), .out_cout(ocout[2]));

    adder_digit_serial #(.p_nbits(32), .p_ndigit(4)) dut3 (
        .clk(clk), .reset(reset), .in_val(iv[3]), .in_rdy(irdy[3]),
        .in_a(a32), .in_b(b32),
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
        .in_sub(sub_sel),
`endif
        .out_val(oval[3]), .out_rdy(ordy[3]), .out_sum(s32), .out_cout(ocout[3]));

    function automatic logic [31:0] get_sum(input int c);
        if (c == 3) return s32;
        return {24'b0, s8[c]};
    endfunction

    // Reference: plain modular add, or subtract with cout meaning "no borrow"
    function automatic logic [32:0] model(input int c, input logic [31:0] a, input logic [31:0] b,
                                          input logic sub);
        logic [31:0] m;
        logic [31:0] am;
        logic [31:0] bm;
        longint      t;
        logic        co;
        m  = (c == 3) ? 32'hFFFF_FFFF : 32'h0000_00FF;
        am = a & m;
        bm = b & m;
        if (sub) begin
            t  = longint'(am) - longint'(bm);
            co = (am >= bm);
        end else begin
            t  = longint'(am) + longint'(bm);
            co = (t > longint'(m));
        end
        return {co, 32'(t) & m};
    endfunction

    task automatic set_ops(input int c, input logic [31:0] a, input logic [31:0] b);
        if (c == 3) begin
            a32 = a;
            b32 = b;
        end else begin
            a8[c] = a[7:0];
            b8[c] = b[7:0];
        end
    endtask

    task automatic run_op(input int c, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] sum, output logic cout, output int lat);
        int guard = 0;
        while (!irdy[c] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        set_ops(c, a, b);
        iv[c]   = 1'b1;
        ordy[c] = 1'b1;
        @(posedge clk); #1;
        iv[c] = 1'b0;
        set_ops(c, $urandom, $urandom);
        lat = 0;
        while (!oval[c] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        sum  = get_sum(c);
        cout = ocout[c];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (irdy[c] !== 1'b1 || oval[c] !== 1'b0 || get_sum(c) !== 32'd0 || ocout[c] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state cfg%0d: rdy=%b val=%b sum=%h cout=%b, want 1 0 0 0",
                         c, irdy[c], oval[c], get_sum(c), ocout[c]);
            end
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [31:0] s;
        logic        co;
        int          lat;
        run_op(0, 32'd3, 32'd5, s, co, lat);
        n_cmp++;
        if (s !== 32'd8 || co !== 1'b0) begin
            n_err++;
            $display("FAIL basic_3p5: sum=%0d cout=%b, want 8 0", s, co);
        end
        n_cmp++;
        if (lat !== 4) begin
            n_err++;
            $display("FAIL basic_latency: got %0d, want 4", lat);
        end
        run_op(0, 32'h7F, 32'h01, s, co, lat);
        n_cmp++;
        if (s !== 32'h80 || co !== 1'b0) begin
            n_err++;
            $display("FAIL basic_7F_p1: sum=%h cout=%b, want 80 0", s, co);
        end
    endtask

    task automatic test_carry();
        logic [31:0] ta [3] = '{32'hFF, 32'h80, 32'hAA};
        logic [31:0] tb [3] = '{32'h01, 32'h80, 32'h55};
        logic [31:0] ts [3] = '{32'h00, 32'h00, 32'hFF};
        logic        tc [3] = '{1'b1, 1'b1, 1'b0};
        logic [31:0] s;
        logic        co;
        int          lat;
        for (int i = 0; i < 3; i++) begin
            run_op(0, ta[i], tb[i], s, co, lat);
            n_cmp++;
            if (s !== ts[i] || co !== tc[i]) begin
                n_err++;
                $display("FAIL carry_%h_p_%h: sum=%h cout=%b, want %h %b", ta[i], tb[i], s, co, ts[i], tc[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] s;
        logic        co;
        int          lat;
        int          guard = 0;
        while (!irdy[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        set_ops(0, 32'd12, 32'd9);
        iv[0]   = 1'b1;
        ordy[0] = 1'b0;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        lat = 0;
        while (!oval[0] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat !== 4 || s8[0] !== 8'd21) begin
            n_err++;
            $display("FAIL bp_first_result: lat=%0d sum=%0d, want 4 21", lat, s8[0]);
        end
        for (int i = 0; i < 5; i++) begin
            iv[0] = 1'b1;
            set_ops(0, 32'd1, 32'd1);
            @(posedge clk); #1;
            n_cmp++;
            if (oval[0] !== 1'b1 || s8[0] !== 8'd21 || ocout[0] !== 1'b0 || irdy[0] !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold cycle%0d: val=%b sum=%0d cout=%b rdy=%b, want 1 21 0 0",
                         i, oval[0], s8[0], ocout[0], irdy[0]);
            end
        end
        iv[0]   = 1'b0;
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (oval[0] !== 1'b0 || irdy[0] !== 1'b1 || s8[0] !== 8'd21) begin
            n_err++;
            $display("FAIL bp_release: val=%b rdy=%b sum=%0d, want 0 1 21", oval[0], irdy[0], s8[0]);
        end
        run_op(0, 32'd1, 32'd1, s, co, lat);
        n_cmp++;
        if (s !== 32'd2 || co !== 1'b0) begin
            n_err++;
            $display("FAIL bp_next_op: sum=%0d cout=%b, want 2 0", s, co);
        end
    endtask

    task automatic test_reset_midop();
        logic [31:0] s;
        logic        co;
        int          lat;
        int          guard = 0;
        bit          seen = 1'b0;
        while (!irdy[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        set_ops(0, 32'hF0, 32'h0F);
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (s8[0] !== 8'd0 || ocout[0] !== 1'b0 || oval[0] !== 1'b0 || irdy[0] !== 1'b1) begin
            n_err++;
            $display("FAIL midop_reset: sum=%h cout=%b val=%b rdy=%b, want 0 0 0 1",
                     s8[0], ocout[0], oval[0], irdy[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (oval[0] === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL midop_no_val: out_val pulsed=%b, want 0", seen);
        end
        run_op(0, 32'd1, 32'd2, s, co, lat);
        n_cmp++;
        if (s !== 32'd3 || co !== 1'b0 || lat !== 4) begin
            n_err++;
            $display("FAIL midop_after: sum=%0d cout=%b lat=%0d, want 3 0 4", s, co, lat);
        end
    endtask

    task automatic test_params();
        logic [31:0] s;
        logic        co;
        int          lat;
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        run_op(1, 32'd200, 32'd100, s, co, lat);
        n_cmp++;
        if (s !== 32'd44 || co !== 1'b1 || lat !== 1) begin
            n_err++;
            $display("FAIL cfg8x8: sum=%0d cout=%b lat=%0d, want 44 1 1", s, co, lat);
        end
        ra = $urandom & 32'hFF;
        rb = $urandom & 32'hFF;
        e  = model(2, ra, rb, 1'b0);
        run_op(2, ra, rb, s, co, lat);
        n_cmp++;
        if (s !== e[31:0] || co !== e[32] || lat !== 8) begin
            n_err++;
            $display("FAIL cfg8x1: sum=%h cout=%b lat=%0d, want %h %b 8", s, co, lat, e[31:0], e[32]);
        end
        run_op(3, 32'hFFFF_FFFF, 32'd1, s, co, lat);
        n_cmp++;
        if (s !== 32'd0 || co !== 1'b1 || lat !== 8) begin
            n_err++;
            $display("FAIL cfg32x4: sum=%h cout=%b lat=%0d, want 0 1 8", s, co, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        logic        co;
        int          lat;
        logic [32:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
                sub_sel = 1'($urandom_range(0, 1));
`endif
                e = model(c, ra, rb, sub_sel);
                run_op(c, ra, rb, s, co, lat);
                n_cmp++;
                if (s !== e[31:0] || co !== e[32] || lat !== exp_lat[c]) begin
                    n_err++;
                    $display("FAIL random cfg%0d a=%h b=%h sub=%b: sum=%h cout=%b lat=%0d, want %h %b %0d",
                             c, ra, rb, sub_sel, s, co, lat, e[31:0], e[32], exp_lat[c]);
                end
            end
        end
        sub_sel = 1'b0;
    endtask

`ifdef ADDER_DIGIT_SERIAL_SUB_EN
    task automatic test_sub();
        logic [31:0] s;
        logic        co;
        int          lat;
        sub_sel = 1'b1;
        run_op(0, 32'd5, 32'd7, s, co, lat);
        n_cmp++;
        if (s !== 32'hFE || co !== 1'b0) begin
            n_err++;
            $display("FAIL sub_5m7: sum=%h cout=%b, want fe 0", s, co);
        end
        run_op(0, 32'd9, 32'd4, s, co, lat);
        n_cmp++;
        if (s !== 32'd5 || co !== 1'b1) begin
            n_err++;
            $display("FAIL sub_9m4: sum=%0d cout=%b, want 5 1", s, co);
        end
        sub_sel = 1'b0;
        run_op(0, 32'd9, 32'd4, s, co, lat);
        n_cmp++;
        if (s !== 32'd13 || co !== 1'b0) begin
            n_err++;
            $display("FAIL sub_off_9p4: sum=%0d cout=%b, want 13 0", s, co);
        end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < 4; c++) begin
            iv[c]   = 1'b0;
            ordy[c] = 1'b1;
        end
        for (int c = 0; c < 3; c++) begin
            a8[c] = 8'd0;
            b8[c] = 8'd0;
        end
        a32 = 32'd0;
        b32 = 32'd0;

        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_midop();
        test_params();
`ifdef ADDER_DIGIT_SERIAL_SUB_EN
        test_sub();
`endif
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_digit_serial.md
Name: adder_digit_serial

Overview:
- Parametrised multi-cycle adder; the sequential successor to the combinational 4-bit adder.
- Adds two p_nbits operands p_ndigit bits per cycle, ripple-carrying between digits through a carry register.
- Latency/bandwidth follow p_ndigit, trading area for throughput.
- val/rdy handshakes on input and output; sits between val/rdy producers/consumers in datapath labs.

Parameters:
- p_nbits, 8, operand and sum width; must be ≥1.
- p_ndigit, 2, bits added per cycle; must divide p_nbits exactly; p_ndigit == p_nbits gives a single-cycle CALC.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  1  operands valid.
- in_rdy  output  1  block can accept operands.
- in_a  input  p_nbits  operand A.
- in_b  input  p_nbits  operand B.
- out_val  output  1  result valid.
- out_rdy  input  1  consumer can accept result.
- out_sum  output  p_nbits  (A + B) mod 2^p_nbits.
- out_cout  output  1  carry out of the MSB.

Behaviour:
- Derived constant: N = p_nbits / p_ndigit digits; counter width clog2(N), minimum 1 bit.
- Registers: a_reg, b_reg, sum_reg, carry_reg, digit counter, state. All are cleared asynchronously when reset is high.
- FSM states: IDLE, CALC, DONE. Reset forces IDLE.
- Outputs after reset: in_rdy=1, out_val=0, out_sum=0, out_cout=0.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in_val (input fire): latch in_a/in_b, set carry_reg=0, counter=0, go to CALC.
- CALC:
  - in_rdy=0, out_val=0.
  - Each cycle: {c, d} = a_reg[p_ndigit-1:0] + b_reg[p_ndigit-1:0] + carry_reg.
  - carry_reg ← c.
  - sum_reg ← {d, sum_reg[p_nbits-1:p_ndigit]} (digits fill LSB-first, ending aligned).
  - a_reg and b_reg shift right by p_ndigit.
  - Counter increments each cycle.
  - When counter == N-1, this cycle's update is the last one; go to DONE.
- DONE:
  - out_val=1, in_rdy=0; out_sum=sum_reg, out_cout=carry_reg.
  - Results hold stable while out_rdy=0.
  - On out_rdy: go to IDLE.
- Timing: input fire at edge k → out_val high from edge k+N. Minimum initiation interval is N+2 cycles, with no overlap of operations.
- out_sum and out_cout are driven from registers in all states and hold their last values outside DONE.
- Simultaneous events:
  - in_val during CALC/DONE is ignored (in_rdy=0); the producer must hold.
  - out_rdy while not in DONE has no effect.
- Reset mid-operation: the asynchronous clear aborts the computation immediately; partial results are discarded and no out_val pulse occurs.
- Operands in_a/in_b may change freely after the input fire.

Optional Feature:
- Macro: ADDER_DIGIT_SERIAL_SUB_EN.
- With the macro defined:
  - Extra port in_sub (input, 1), sampled at input fire.
  - When in_sub=1: b_reg latches ~in_b and carry_reg initialises to 1, so out_sum = (A − B) mod 2^p_nbits and out_cout = 1 means no borrow (A ≥ B unsigned).
  - When in_sub=0: behaviour is identical to the add-only build.
- Without the macro: the in_sub port does not exist; the block is add-only.

Test Plan:
- Basic add, p_nbits=8, p_ndigit=2: A=3, B=5, out_rdy=1 → out_val exactly 4 cycles after fire; sum=8, cout=0. Also 0x7F+0x01 → 0x80, cout=0.
- Overflow/carry ripple across all digits: 0xFF+0x01 → sum=0x00, cout=1; 0x80+0x80 → sum=0x00, cout=1; 0xAA+0x55 → 0xFF, cout=0.
- Back-pressure, checked with 12+9:
  - Hold out_rdy=0 for 5 cycles after out_val → out_val stays 1, sum=21 held stable, in_rdy=0.
  - in_val asserted with A=1, B=1 during this time is not accepted.
  - After out_rdy=1, the next fire yields 2.
- Reset mid-op:
  - Fire 0xF0+0x0F, assert reset in cycle 2 of CALC → outputs immediately 0/0/0, in_rdy=1, no out_val.
  - A subsequent 1+2 yields 3.
- Parameter sweep: (p_nbits, p_ndigit) = (8,8) → latency 1, 200+100=44 cout=1; (8,1) → latency 8; (32,4) → 0xFFFFFFFF+1 → 0, cout=1, latency 8. Random 1000 vectors against a behavioural + model per configuration.
- With ADDER_DIGIT_SERIAL_SUB_EN, p_nbits=8:
  - in_sub=1, 5−7 → sum=0xFE, cout=0.
  - 9−4 → 5, cout=1.
  - in_sub=0, 9+4 → 13.
